// File: rtl/uart_ctrl.sv
// Memory-mapped UART controller: TX byte queue feeding a transmitter core through a
// small handshake FSM, RX holding register with overrun detection, and a level interrupt.
module uart_ctrl #(
  parameter int TXQ_DEPTH = 4
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_idle,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        irq
);

  localparam int PW = $clog2(TXQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(TXQ_DEPTH);

  localparam logic [31:0] TXD_ADDR = 32'h4000_0018;
  localparam logic [31:0] RXD_ADDR = 32'h4000_001C;
  localparam logic [31:0] CON_ADDR = 32'h4000_0020;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

  tx_state_e         state_q, state_d;
  logic [7:0]        mem_q [TXQ_DEPTH];
  logic [7:0]        mem_d [TXQ_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              txie_q, txie_d;
  logic              rxie_q, rxie_d;
  logic              txdone_q, txdone_d;
  logic              rx_full_q, rx_full_d;
  logic              ovr_q, ovr_d;
  logic [7:0]        rx_hold_q, rx_hold_d;
  logic              irq_q, irq_d;

  logic              sel_txd_s, sel_rxd_s, sel_con_s;
  logic              wr_txd_s, wr_con_s, rd_rxd_s, rd_con_s;
  logic              q_full_s, q_empty_s, tx_busy_s;
  logic              push_s, pop_s, tx_done_set_s;
  logic [31:0]       con_s;
  logic              unused_wdata_s;

  assign sel_txd_s = (addr == TXD_ADDR);
  assign sel_rxd_s = (addr == RXD_ADDR);
  assign sel_con_s = (addr == CON_ADDR);
  assign wr_txd_s  = MemWrite & sel_txd_s;
  assign wr_con_s  = MemWrite & sel_con_s;
  assign rd_rxd_s  = MemRead & sel_rxd_s;
  assign rd_con_s  = MemRead & sel_con_s;

  // Fullness is judged on the registered count, so a same-cycle pop never frees a slot for a push.
  assign q_full_s  = (count_q == DEPTH_C);
  assign q_empty_s = (count_q == {CW{1'b0}});
  assign push_s    = wr_txd_s & ~q_full_s;
  assign pop_s     = (state_q == IDLE) & ~q_empty_s & tx_idle;
  assign tx_busy_s = (state_q != IDLE) | ~q_empty_s;

  assign con_s = {25'h0, tx_busy_s, ovr_q, q_full_s, rx_full_q, txdone_q, rxie_q, txie_q};
  assign unused_wdata_s = ^WriteData[31:8];

  // CPU read mux
  always_comb begin
    ReadData = 32'h0;
    if (MemRead) begin
      if (sel_rxd_s) begin
        ReadData = {24'h0, rx_hold_q};
      end else if (sel_con_s) begin
        ReadData = con_s;
      end else begin
        ReadData = 32'h0;
      end
    end else begin
      ReadData = 32'h0;
    end
  end

  // TX queue next state
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = WriteData[7:0];
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // TX handshake FSM
  always_comb begin
    state_d       = state_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    tx_done_set_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop_s) begin
          state_d    = START;
          tx_data_d  = mem_q[rd_ptr_q];
          tx_start_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      START: state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!tx_idle) begin
          state_d = WAIT_DONE;
        end else begin
          state_d = WAIT_BUSY;
        end
      end
      WAIT_DONE: begin
        if (tx_idle) begin
          state_d       = IDLE;
          tx_done_set_s = 1'b1;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status bits: set events outrank read-clears
  always_comb begin
    txie_d    = wr_con_s ? WriteData[0] : txie_q;
    rxie_d    = wr_con_s ? WriteData[1] : rxie_q;
    rx_hold_d = rx_valid ? rx_data : rx_hold_q;
    if (tx_done_set_s) begin
      txdone_d = 1'b1;
    end else if (rd_con_s) begin
      txdone_d = 1'b0;
    end else begin
      txdone_d = txdone_q;
    end
    if (rx_valid) begin
      rx_full_d = 1'b1;
    end else if (rd_rxd_s) begin
      rx_full_d = 1'b0;
    end else begin
      rx_full_d = rx_full_q;
    end
    if (rx_valid & rx_full_q & ~rd_rxd_s) begin
      ovr_d = 1'b1;
    end else if (rd_con_s) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
    irq_d = (txie_q & txdone_q) | (rxie_q & rx_full_q);
  end

  // State registers
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      for (int i = 0; i < TXQ_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      txie_q     <= 1'b0;
      rxie_q     <= 1'b0;
      txdone_q   <= 1'b0;
      rx_full_q  <= 1'b0;
      ovr_q      <= 1'b0;
      rx_hold_q  <= 8'h00;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      txie_q     <= txie_d;
      rxie_q     <= rxie_d;
      txdone_q   <= txdone_d;
      rx_full_q  <= rx_full_d;
      ovr_q      <= ovr_d;
      rx_hold_q  <= rx_hold_d;
      irq_q      <= irq_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign irq      = irq_q;

endmodule
